// File: rtl/alu_seq.sv
// alu_seq: registered 8085-style ALU with rotates, INC/DEC and a multi-cycle
// shift-add unsigned multiply. Single-cycle ops complete at the accepting
// edge. MUL takes DATASIZE+1 edges from start to oDone.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   iStart        : accept iS/iA/iB when oBusy is low
//   iS            : operation select (0..15)
//   iA, iB        : operands
//   iFLd, iF      : direct load of the flag register
//   oY, oYH       : result / product low half, product high half
//   oF            : flag register; unnamed bit positions read 0
//   oBusy, oDone  : multiply in progress / one-cycle result-valid pulse
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for iStart; single-cycle ops complete here
// ST_MULT    | one shift-add step per edge until the counter reaches 0

module alu_seq #(
    parameter int DATASIZE = 8,
    parameter int FLAG_S   = 7,
    parameter int FLAG_Z   = 6,
    parameter int FLAG_A   = 4,
    parameter int FLAG_P   = 2,
    parameter int FLAG_C   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic [3:0]          iS,
    input  logic [DATASIZE-1:0] iA,
    input  logic [DATASIZE-1:0] iB,
    input  logic                iFLd,
    input  logic [7:0]          iF,
    output logic [DATASIZE-1:0] oY,
    output logic [DATASIZE-1:0] oYH,
    output logic [7:0]          oF,
    output logic                oBusy,
    output logic                oDone
);

    localparam int W1 = DATASIZE + 1;
    localparam int CW = $clog2(DATASIZE + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MULT = 1'b1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_RLC = 4'd8;
    localparam logic [3:0] OP_RRC = 4'd9;
    localparam logic [3:0] OP_RAL = 4'd10;
    localparam logic [3:0] OP_RAR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_INC = 4'd13;
    localparam logic [3:0] OP_DEC = 4'd14;

    // Only the named flag positions are storage; the rest stay 0.
    localparam logic [7:0] FMASK = (8'd1 << FLAG_S) | (8'd1 << FLAG_Z) |
                                   (8'd1 << FLAG_A) | (8'd1 << FLAG_P) |
                                   (8'd1 << FLAG_C);

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATASIZE-1:0]   mcand_q, mcand_d;
    // {partial product high half, remaining multiplier bits}
    logic [2*DATASIZE-1:0] prod_q, prod_d;
    logic [DATASIZE-1:0]   y_q, y_d;
    logic [DATASIZE-1:0]   yh_q, yh_d;
    logic [7:0]            flag_q, flag_d;
    logic                  done_q, done_d;

    logic                  cin;
    logic                  cy;
    logic [W1-1:0]         ext;
    logic [4:0]            nib;
    logic [DATASIZE-1:0]   alu_y;
    logic [DATASIZE-1:0]   szp_val;
    logic                  upd_szp;
    logic                  c_new;
    logic                  a_new;
    logic                  alu_wr_f;
    logic [7:0]            alu_f;

    logic [W1-1:0]         hi_sum;
    logic [2*DATASIZE-1:0] prod_step;
    logic [7:0]            mul_f;

    assign cin = flag_q[FLAG_C];

    // Single-cycle datapath: result and flag image for the current iS.
    always_comb begin
        alu_y    = iA;
        szp_val  = '0;
        upd_szp  = 1'b0;
        c_new    = flag_q[FLAG_C];
        a_new    = flag_q[FLAG_A];
        alu_wr_f = 1'b1;
        ext      = '0;
        nib      = '0;
        cy       = 1'b0;
        case (iS)
            OP_ADD, OP_ADC: begin
                cy      = (iS == OP_ADC) ? cin : 1'b0;
                ext     = {1'b0, iA} + {1'b0, iB} + W1'(cy);
                nib     = {1'b0, iA[3:0]} + {1'b0, iB[3:0]} + 5'(cy);
                alu_y   = ext[DATASIZE-1:0];
                szp_val = ext[DATASIZE-1:0];
                c_new   = ext[DATASIZE];
                a_new   = nib[4];
                upd_szp = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                // Bit DATASIZE of the widened difference is the borrow.
                cy      = (iS == OP_SBB) ? cin : 1'b0;
                ext     = {1'b0, iA} - {1'b0, iB} - W1'(cy);
                nib     = {1'b0, iA[3:0]} - {1'b0, iB[3:0]} - 5'(cy);
                alu_y   = (iS == OP_CMP) ? iA : ext[DATASIZE-1:0];
                szp_val = ext[DATASIZE-1:0];
                c_new   = ext[DATASIZE];
                a_new   = nib[4];
                upd_szp = 1'b1;
            end
            OP_AND, OP_XOR, OP_OR: begin
                if (iS == OP_AND) begin
                    alu_y = iA & iB;
                end else if (iS == OP_XOR) begin
                    alu_y = iA ^ iB;
                end else begin
                    alu_y = iA | iB;
                end
                szp_val = alu_y;
                c_new   = 1'b0;
                a_new   = 1'b0;
                upd_szp = 1'b1;
            end
            OP_RLC: begin
                alu_y = {iA[DATASIZE-2:0], iA[DATASIZE-1]};
                c_new = iA[DATASIZE-1];
            end
            OP_RRC: begin
                alu_y = {iA[0], iA[DATASIZE-1:1]};
                c_new = iA[0];
            end
            OP_RAL: begin
                alu_y = {iA[DATASIZE-2:0], cin};
                c_new = iA[DATASIZE-1];
            end
            OP_RAR: begin
                alu_y = {cin, iA[DATASIZE-1:1]};
                c_new = iA[0];
            end
            OP_INC: begin
                ext     = {1'b0, iA} + W1'(1);
                nib     = {1'b0, iA[3:0]} + 5'd1;
                alu_y   = ext[DATASIZE-1:0];
                szp_val = ext[DATASIZE-1:0];
                a_new   = nib[4];
                upd_szp = 1'b1;
            end
            OP_DEC: begin
                ext     = {1'b0, iA} - W1'(1);
                nib     = {1'b0, iA[3:0]} - 5'd1;
                alu_y   = ext[DATASIZE-1:0];
                szp_val = ext[DATASIZE-1:0];
                a_new   = nib[4];
                upd_szp = 1'b1;
            end
            default: begin
                // Pass-through (15); MUL never takes this path as a result.
                alu_wr_f = 1'b0;
            end
        endcase

        alu_f = flag_q;
        if (upd_szp) begin
            alu_f[FLAG_S] = szp_val[DATASIZE-1];
            alu_f[FLAG_Z] = (szp_val == '0);
            alu_f[FLAG_P] = ~^szp_val;
        end
        alu_f[FLAG_C] = c_new;
        alu_f[FLAG_A] = a_new;
        alu_f         = alu_f & FMASK;
    end

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier lsb is set, then shift the whole register right.
    always_comb begin
        if (prod_q[0]) begin
            hi_sum = {1'b0, prod_q[2*DATASIZE-1:DATASIZE]} + {1'b0, mcand_q};
        end else begin
            hi_sum = {1'b0, prod_q[2*DATASIZE-1:DATASIZE]};
        end
        prod_step = {hi_sum, prod_q[DATASIZE-1:1]};

        mul_f         = '0;
        mul_f[FLAG_S] = prod_step[2*DATASIZE-1];
        mul_f[FLAG_Z] = (prod_step == '0);
        mul_f[FLAG_P] = ~^prod_step[DATASIZE-1:0];
        mul_f[FLAG_C] = |prod_step[2*DATASIZE-1:DATASIZE];
        mul_f         = mul_f & FMASK;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        y_d     = y_q;
        yh_d    = yh_q;
        flag_d  = flag_q;
        done_d  = 1'b0;

        // A direct load applies unless a result also writes flags this edge.
        if (iFLd) begin
            flag_d = iF & FMASK;
        end

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    if (iS == OP_MUL) begin
                        mcand_d = iA;
                        prod_d  = {{DATASIZE{1'b0}}, iB};
                        cnt_d   = CW'(DATASIZE);
                        state_d = ST_MULT;
                    end else begin
                        y_d    = alu_y;
                        yh_d   = '0;
                        done_d = 1'b1;
                        if (alu_wr_f) begin
                            flag_d = alu_f;
                        end
                    end
                end
            end
            ST_MULT: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    y_d     = prod_step[DATASIZE-1:0];
                    yh_d    = prod_step[2*DATASIZE-1:DATASIZE];
                    flag_d  = mul_f;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            y_q     <= '0;
            yh_q    <= '0;
            flag_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            y_q     <= y_d;
            yh_q    <= yh_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    assign oY    = y_q;
    assign oYH   = yh_q;
    assign oF    = flag_q;
    assign oBusy = (state_q == ST_MULT);
    assign oDone = done_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam logic [7:0] FM = 8'hD5;

    logic       clk;
    logic       rst;
    logic       iStart;
    logic [3:0] iS;
    logic [7:0] iA;
    logic [7:0] iB;
    logic       iFLd;
    logic [7:0] iF;
    logic [7:0] oY;
    logic [7:0] oYH;
    logic [7:0] oF;
    logic       oBusy;
    logic       oDone;

    int n_cmp = 0;
    int n_err = 0;
    bit sim_end = 0;

    // reference model state
    logic [7:0]  m_y    = 8'h00;
    logic [7:0]  m_yh   = 8'h00;
    logic [7:0]  m_f    = 8'h00;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [15:0] m_prod = 16'h0000;

    alu_seq #(.DATASIZE(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .iStart(iStart),
        .iS    (iS),
        .iA    (iA),
        .iB    (iB),
        .iFLd  (iFLd),
        .iF    (iF),
        .oY    (oY),
        .oYH   (oYH),
        .oF    (oF),
        .oBusy (oBusy),
        .oDone (oDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Spec-level result of a single-cycle op in plain integer arithmetic.
    task automatic model_op(input int op, input int a, input int b,
                            input logic [7:0] f, output int y,
                            output logic [7:0] nf, output bit wr);
        int r;
        int res;
        int c;
        int ac;
        int cin;
        bit szp;
        logic [7:0] rb;
        cin = int'(f[0]);
        c   = cin;
        ac  = int'(f[4]);
        wr  = 1;
        szp = 0;
        y   = a;
        res = 0;
        case (op)
            0, 1: begin
                r   = a + b + ((op == 1) ? cin : 0);
                res = r & 255;
                y   = res;
                c   = (r > 255) ? 1 : 0;
                ac  = (((a & 15) + (b & 15) + ((op == 1) ? cin : 0)) > 15) ? 1 : 0;
                szp = 1;
            end
            2, 3, 7: begin
                r   = a - b - ((op == 3) ? cin : 0);
                res = r & 255;
                y   = (op == 7) ? a : res;
                c   = (r < 0) ? 1 : 0;
                ac  = (((a & 15) - (b & 15) - ((op == 3) ? cin : 0)) < 0) ? 1 : 0;
                szp = 1;
            end
            4: begin res = a & b; y = res; c = 0; ac = 0; szp = 1; end
            5: begin res = a ^ b; y = res; c = 0; ac = 0; szp = 1; end
            6: begin res = a | b; y = res; c = 0; ac = 0; szp = 1; end
            8:  begin y = ((a * 2) & 255) | (a / 128); c = a / 128; end
            9:  begin y = (a / 2) | ((a % 2) * 128);   c = a % 2;   end
            10: begin y = ((a * 2) & 255) | cin;       c = a / 128; end
            11: begin y = (a / 2) | (cin * 128);       c = a % 2;   end
            13: begin
                res = (a + 1) & 255; y = res;
                ac  = ((a & 15) == 15) ? 1 : 0;
                szp = 1;
            end
            14: begin
                res = (a + 255) & 255; y = res;
                ac  = ((a & 15) == 0) ? 1 : 0;
                szp = 1;
            end
            default: wr = 0;
        endcase
        nf = f;
        if (szp) begin
            rb    = res[7:0];
            nf[7] = rb[7];
            nf[6] = (res == 0);
            nf[2] = ($countones(rb) % 2 == 0);
        end
        nf[0] = c[0];
        nf[4] = ac[0];
        nf    = nf & FM;
    endtask

    always @(posedge clk or posedge rst) begin : model
        int         y_t;
        logic [7:0] nf_t;
        bit         wr_t;
        logic [7:0] t_y;
        logic [7:0] t_yh;
        logic [7:0] t_f;
        logic       t_busy;
        logic       t_done;
        int         t_left;
        logic [15:0] t_prod;
        if (rst) begin
            m_y    <= 8'h00;
            m_yh   <= 8'h00;
            m_f    <= 8'h00;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_prod <= 16'h0000;
        end else begin
            t_y = m_y; t_yh = m_yh; t_f = m_f; t_busy = m_busy;
            t_left = m_left; t_prod = m_prod; t_done = 1'b0;
            if (iFLd) t_f = iF & FM;
            if (m_busy) begin
                t_left = m_left - 1;
                if (t_left == 0) begin
                    t_busy = 1'b0;
                    t_done = 1'b1;
                    t_y    = m_prod[7:0];
                    t_yh   = m_prod[15:8];
                    t_f    = 8'h00;
                    t_f[7] = m_prod[15];
                    t_f[6] = (m_prod == 16'h0000);
                    t_f[2] = ($countones(m_prod[7:0]) % 2 == 0);
                    t_f[0] = (m_prod[15:8] != 8'h00);
                end
            end else if (iStart) begin
                if (iS == 4'd12) begin
                    t_prod = 16'(iA) * 16'(iB);
                    t_left = 8;
                    t_busy = 1'b1;
                end else begin
                    model_op(int'(iS), int'(iA), int'(iB), m_f, y_t, nf_t, wr_t);
                    t_y    = y_t[7:0];
                    t_yh   = 8'h00;
                    t_done = 1'b1;
                    if (wr_t) t_f = nf_t;
                end
            end
            m_y <= t_y; m_yh <= t_yh; m_f <= t_f; m_busy <= t_busy;
            m_done <= t_done; m_left <= t_left; m_prod <= t_prod;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!sim_end) begin
            n_cmp++;
            if ({oY, oYH, oF, oBusy, oDone} !== {m_y, m_yh, m_f, m_busy, m_done}) begin
                n_err++;
                $display("FAIL model t=%0t: got Y=%h YH=%h F=%h busy=%b done=%b, want Y=%h YH=%h F=%h busy=%b done=%b",
                         $time, oY, oYH, oF, oBusy, oDone, m_y, m_yh, m_f, m_busy, m_done);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns #1 after the next one.
    task automatic op1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        iStart = 1'b1; iS = op; iA = a; iB = b;
        @(negedge clk);
        iStart = 1'b0;
        #1;
    endtask

    task automatic load_f(input logic [7:0] v);
        iFLd = 1'b1; iF = v;
        @(negedge clk);
        iFLd = 1'b0;
        #1;
        check("flag_load", {24'h0, oF}, {24'h0, v & FM});
    endtask

    task automatic idle1();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iStart = 1'b0; iS = 4'd0; iA = 8'h00; iB = 8'h00;
        iFLd = 1'b0; iF = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {oY, oYH, oF, 5'b0, oBusy, oDone}, 32'h0);
        rst = 1'b0;

        op1(4'd0, 8'hFF, 8'h01);
        check("add_y", {24'h0, oY}, 32'h00);
        check("add_f", {24'h0, oF}, 32'h55);
        check("add_done", {31'h0, oDone}, 32'h1);
        idle1();
        check("add_done_clear", {31'h0, oDone}, 32'h0);

        op1(4'd1, 8'h10, 8'h20);
        check("adc_y", {24'h0, oY}, 32'h31);
        check("adc_f", {24'h0, oF}, 32'h00);
        load_f(8'h01);
        op1(4'd3, 8'h00, 8'h00);
        check("sbb_y", {24'h0, oY}, 32'hFF);
        check("sbb_f", {24'h0, oF}, 32'h95);

        // MUL 0xFF*0xFF with an ignored start while busy
        op1(4'd12, 8'hFF, 8'hFF);
        check("mul_busy_0", {31'h0, oBusy}, 32'h1);
        for (int k = 1; k < 8; k++) begin
            if (k == 3) begin iStart = 1'b1; iS = 4'd0; iA = 8'h01; iB = 8'h01; end
            else iStart = 1'b0;
            @(negedge clk);
            #1;
            check("mul_busy", {30'h0, oBusy, oDone}, 32'h2);
        end
        iStart = 1'b0;
        idle1();
        check("mul_done", {30'h0, oBusy, oDone}, 32'h1);
        check("mul_y", {16'h0, oYH, oY}, 32'hFE01);
        check("mul_f", {24'h0, oF}, 32'h81);
        idle1();
        check("mul_done_clear", {31'h0, oDone}, 32'h0);

        op1(4'd10, 8'h80, 8'h00);
        check("ral_y", {24'h0, oY}, 32'h01);
        check("ral_f", {24'h0, oF}, 32'h81);
        op1(4'd9, 8'h01, 8'h00);
        check("rrc_y", {24'h0, oY}, 32'h80);
        check("rrc_f", {24'h0, oF}, 32'h81);

        load_f(8'h00);
        op1(4'd13, 8'hFF, 8'h00);
        check("inc_y", {24'h0, oY}, 32'h00);
        check("inc_f", {24'h0, oF}, 32'h54);
        op1(4'd7, 8'h05, 8'h07);
        check("cmp_y", {24'h0, oY}, 32'h05);
        check("cmp_f", {24'h0, oF}, 32'h91);

        // reset during the 4th MULT cycle
        op1(4'd12, 8'h0F, 8'h0F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {oY, oYH, oF, 5'b0, oBusy, oDone}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        repeat (10) begin
            idle1();
            check("abort_no_done", {31'h0, oDone}, 32'h0);
        end
        op1(4'd0, 8'h02, 8'h03);
        check("post_reset_add", {16'h0, oY, oF}, 32'h0504);
        check("post_reset_done", {31'h0, oDone}, 32'h1);

        // randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            iStart = ($urandom_range(0, 1) == 1);
            iS     = 4'($urandom_range(0, 15));
            iA     = 8'($urandom);
            iB     = 8'($urandom);
            iFLd   = ($urandom_range(0, 7) == 0);
            iF     = 8'($urandom);
            // Keep direct loads off edges where rotates/pass-through may be accepted.
            if (iStart && (iS >= 4'd8) && (iS != 4'd12) && (iS <= 4'd11 || iS == 4'd15))
                iFLd = 1'b0;
            @(negedge clk);
            #1;
        end
        iStart = 1'b0; iFLd = 1'b0;
        repeat (12) idle1();

        sim_end = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the core85 combinational ALU.
- Keeps the eight 8085-style base ops and adds rotates, INC/DEC and a multi-cycle unsigned multiply.
- Holds an internal flag register and uses a start/busy/done handshake.
- Sits between the register file and the accumulator write-back in the next-generation datapath.

Parameters:
- DATASIZE, 8, operand/result width in bits; legal range is 4 and above.
- FLAG_S, 7, sign bit position in the flag register.
- FLAG_Z, 6, zero bit position in the flag register.
- FLAG_A, 4, auxiliary-carry bit position in the flag register.
- FLAG_P, 2, parity bit position in the flag register.
- FLAG_C, 0, carry bit position in the flag register.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- iStart  in  1  accepts iS/iA/iB when high and oBusy is low.
- iS  in  4  operation select.
- iA  in  DATASIZE  operand A.
- iB  in  DATASIZE  operand B.
- iFLd  in  1  loads iF into the flag register.
- iF  in  8  flag load value.
- oY  out  DATASIZE  result, or product low half.
- oYH  out  DATASIZE  product high half; zero for non-MUL ops.
- oF  out  8  flag register; bits not named by a FLAG_* parameter read 0.
- oBusy  out  1  high while a multiply is in progress.
- oDone  out  1  one-cycle pulse when a result is valid.

Behaviour:
- Reset (asynchronous, rst=1): oY=0, oYH=0, oF=0, oBusy=0, oDone=0, state=IDLE, counter=0.
- States:
  - IDLE: iStart with iS!=12 computes at that edge; oY/oF update and oDone=1 for the next cycle; stays in IDLE (latency 1).
  - IDLE with iStart and iS=12 (MUL): latch operands, clear accumulator, counter=DATASIZE; go to MULT; oBusy=1 from the following cycle.
  - MULT: one shift-add step per cycle; counter decrements.
  - MULT, counter reaching 0: write product, oDone=1 for one cycle, oBusy=0, back to IDLE.
  - MUL latency is DATASIZE+1 edges from start to oDone.
- oDone clears on the cycle after any pulse unless a new single-cycle op is accepted back-to-back.
- Back-to-back single-cycle ops give one oDone per start.
- iStart while oBusy=1 is ignored: no effect, no queuing.
- iFLd:
  - Loads oF at any edge when no result is written at that edge.
  - If a result writes flags at the same edge, the result wins.
  - iFLd during MULT loads immediately; the MUL result later overwrites it.
- Ops, where cin is oF[FLAG_C] (the registered flag):
  - 0 ADD: A+B.
  - 1 ADC: A+B+cin.
  - 2 SUB: A-B.
  - 3 SBB: A-B-cin.
  - 4 AND: A&B.
  - 5 XOR: A^B.
  - 6 OR: A|B.
  - 7 CMP: oY=A; flags as SUB.
  - 8 RLC: rotate left; C = old msb.
  - 9 RRC: rotate right; C = old lsb.
  - 10 RAL: rotate left through C.
  - 11 RAR: rotate right through C.
  - 12 MUL: unsigned A*B, 2*DATASIZE bits, high half on oYH.
  - 13 INC: A+1; C unchanged.
  - 14 DEC: A-1; C unchanged.
  - 15: oY=A; flags unchanged.
- Arithmetic flags:
  - C = carry out of the msb.
  - For SUB/SBB/CMP, C=1 on borrow, i.e. the result is the low DATASIZE bits of A-B(-cin) and C = bit DATASIZE of the (DATASIZE+1)-bit difference.
  - A = carry/borrow out of bit 3.
- Flags for ops 0-7, 13 and 14:
  - S = result msb.
  - Z = result all-zero.
  - P = 1 when the result has even parity.
- Logic ops 4-6: C=0, A=0.
- Rotates 8-11 change only C.
- MUL flags:
  - S = product msb.
  - Z = full product zero.
  - P = even parity of the low half.
  - A = 0.
  - C = 1 when oYH is nonzero.
- Wrap-around: all results are modulo 2^DATASIZE; INC of all-ones gives 0 with Z=1.
- Reset mid-MULT aborts at once: all outputs return to reset values and no oDone is issued.

Test Plan (DATASIZE=8):
- oF=0; ADD A=0xFF B=0x01 -> oY=0x00, C=1, Z=1, A=1, P=1, S=0; oDone high exactly one cycle after the start edge.
- ADC after that ADD (so C=1), A=0x10 B=0x20 -> oY=0x31, C=0; SBB with C=1, A=0x00 B=0x00 -> oY=0xFF, C=1, S=1, P=1.
- MUL A=0xFF B=0xFF -> oBusy high 8 cycles, then oY=0x01, oYH=0xFE, C=1, oDone pulse 9 edges after start; a second iStart during busy is ignored.
- RAL with C=1, A=0x80 -> oY=0x01, C=1; RRC A=0x01 -> oY=0x80, C=1; S/Z/P unchanged from before.
- INC A=0xFF with C=0 -> oY=0x00, Z=1, C stays 0; CMP A=0x05 B=0x07 -> oY=0x05, C=1, S=1.
- Assert rst during the 4th MULT cycle -> immediate oBusy=0, oY=0, oYH=0, oF=0, no oDone; the next ADD after reset release completes normally.
